// File: rtl/iod_tx_ddrx4_word_feeder.sv
// Fabric-side feeder for one DDRX4 TX IOD lane: gears 8-bit words into nibbles,
// sequences the IOD TX_SYNC_RST after reset, and emits training/idle fill.
module iod_tx_ddrx4_word_feeder #(
  parameter bit          LSB_FIRST     = 1'b1,
  parameter logic [3:0]  IDLE_PATTERN  = 4'b0000,
  parameter logic [3:0]  TRAIN_PATTERN = 4'b0101,
  parameter int unsigned TRAIN_LEN     = 16,
  parameter int unsigned RST_HOLD_CYC  = 8
) (
  input  logic       i_fab_clk,
  input  logic       i_arst,
  input  logic       i_tx_en,
  input  logic       i_train_req,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [3:0] o_tx_data_0,
  output logic [1:0] o_oe_data_0,
  output logic       o_tx_sync_rst,
  output logic       o_train_done,
  output logic       o_underrun
);

  // state | meaning
  // HOLD  | TX_SYNC_RST held high for RST_HOLD_CYC cycles after reset release
  // IDLE  | idle pattern, waiting for training request or TX_EN
  // TRAIN | training pattern burst of TRAIN_LEN cycles
  // DATA  | gearing accepted words into nibbles
  typedef enum logic [1:0] {S_HOLD, S_IDLE, S_TRAIN, S_DATA} state_t;

  localparam logic [7:0] HOLD_LOAD  = 8'(RST_HOLD_CYC - 1);
  localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_word, w_word_nxt;
  logic       r_wv, w_wv_nxt;
  logic       r_ph, w_ph_nxt;
  logic       r_any_acc, w_any_acc_nxt;
  logic       r_train_pend, w_train_pend_nxt;
  logic [3:0] r_tx_data, w_tx_data_nxt;
  logic [1:0] r_oe, w_oe_nxt;
  logic       r_sync_rst, w_sync_rst_nxt;
  logic       r_train_done, w_train_done_nxt;
  logic       r_underrun, w_underrun_nxt;

  logic       w_exit_req, w_word_end, w_to_train, w_ready, w_accept;
  logic [3:0] w_nib_first, w_nib_second;

  assign w_exit_req   = !i_tx_en | i_train_req | r_train_pend;
  assign w_word_end   = !r_wv | r_ph;
  assign w_to_train   = i_train_req | r_train_pend;
  // No new word while the current one still owes its first nibble, nor while leaving DATA.
  assign w_ready      = (r_state == S_DATA) & w_word_end & !w_exit_req;
  assign w_accept     = i_data_valid & w_ready;
  assign w_nib_first  = LSB_FIRST ? r_word[3:0] : r_word[7:4];
  assign w_nib_second = LSB_FIRST ? r_word[7:4] : r_word[3:0];

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_word_nxt       = r_word;
    w_wv_nxt         = r_wv;
    w_ph_nxt         = r_ph;
    w_any_acc_nxt    = r_any_acc;
    w_train_pend_nxt = r_train_pend;
    w_tx_data_nxt    = IDLE_PATTERN;
    w_oe_nxt         = 2'b00;
    w_sync_rst_nxt   = r_sync_rst;
    w_train_done_nxt = r_train_done;
    w_underrun_nxt   = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_sync_rst_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_IDLE: begin
        w_oe_nxt = i_tx_en ? 2'b11 : 2'b00;
        if (i_train_req) begin
          w_state_nxt      = S_TRAIN;
          w_cnt_nxt        = TRAIN_LOAD;
          w_train_done_nxt = 1'b0;
        end else if (i_tx_en) begin
          w_state_nxt      = S_DATA;
          w_any_acc_nxt    = 1'b0;
          w_train_pend_nxt = 1'b0;
        end
      end
      S_TRAIN: begin
        w_oe_nxt      = 2'b11;
        w_tx_data_nxt = TRAIN_PATTERN;
        if (r_cnt == 8'd0) begin
          w_train_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_DATA: begin
        w_oe_nxt = 2'b11;
        if (i_train_req) w_train_pend_nxt = 1'b1;
        if (r_wv) begin
          w_tx_data_nxt = r_ph ? w_nib_second : w_nib_first;
          if (!r_ph) begin
            w_ph_nxt = 1'b1;
          end else if (w_accept) begin
            w_word_nxt = i_data_in;
            w_ph_nxt   = 1'b0;
          end else begin
            w_wv_nxt = 1'b0;
          end
        end else begin
          w_underrun_nxt = r_any_acc;
          if (w_accept) begin
            w_word_nxt = i_data_in;
            w_wv_nxt   = 1'b1;
            w_ph_nxt   = 1'b0;
          end
        end
        if (w_accept) w_any_acc_nxt = 1'b1;
        if (w_exit_req && w_word_end) begin
          if (w_to_train) begin
            w_state_nxt      = S_TRAIN;
            w_cnt_nxt        = TRAIN_LOAD;
            w_train_done_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= S_HOLD;
      r_cnt        <= HOLD_LOAD;
      r_word       <= 8'd0;
      r_wv         <= 1'b0;
      r_ph         <= 1'b0;
      r_any_acc    <= 1'b0;
      r_train_pend <= 1'b0;
      r_tx_data    <= IDLE_PATTERN;
      r_oe         <= 2'b00;
      r_sync_rst   <= 1'b1;
      r_train_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word       <= w_word_nxt;
      r_wv         <= w_wv_nxt;
      r_ph         <= w_ph_nxt;
      r_any_acc    <= w_any_acc_nxt;
      r_train_pend <= w_train_pend_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_oe         <= w_oe_nxt;
      r_sync_rst   <= w_sync_rst_nxt;
      r_train_done <= w_train_done_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  assign o_data_ready  = w_ready;
  assign o_tx_data_0   = r_tx_data;
  assign o_oe_data_0   = r_oe;
  assign o_tx_sync_rst = r_sync_rst;
  assign o_train_done  = r_train_done;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_iod_tx_ddrx4_word_feeder.sv
// Bench for iod_tx_ddrx4_word_feeder: LSB-first and MSB-first instances checked against
// a nibble-queue reference model, plus directed vector table and corner sequences.
module tb_iod_tx_ddrx4_word_feeder;
  localparam int TLEN = 16;
  localparam int HOLD = 8;
  localparam int M_HOLD = 0, M_IDLE = 1, M_TRAIN = 2, M_DATA = 3;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       tx_en = 1'b0, train_req = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'd0;
  logic       rdy_a, rdy_b, sync_a, sync_b, done_a, done_b, und_a, und_b;
  logic [3:0] tx_a, tx_b;
  logic [1:0] oe_a, oe_b;

  always #5 clk = ~clk;

  iod_tx_ddrx4_word_feeder #(.LSB_FIRST(1'b1)) u_lsb (
    .i_fab_clk(clk), .i_arst(arst), .i_tx_en(tx_en), .i_train_req(train_req),
    .i_data_in(data), .i_data_valid(valid), .o_data_ready(rdy_a), .o_tx_data_0(tx_a),
    .o_oe_data_0(oe_a), .o_tx_sync_rst(sync_a), .o_train_done(done_a), .o_underrun(und_a));

  iod_tx_ddrx4_word_feeder #(.LSB_FIRST(1'b0)) u_msb (
    .i_fab_clk(clk), .i_arst(arst), .i_tx_en(tx_en), .i_train_req(train_req),
    .i_data_in(data), .i_data_valid(valid), .o_data_ready(rdy_b), .o_tx_data_0(tx_b),
    .o_oe_data_0(oe_b), .o_tx_sync_rst(sync_b), .o_train_done(done_b), .o_underrun(und_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending nibbles kept as queues in emission order.
  int         m_mode, m_left;
  bit         m_any, m_pend, last_acc, last_rdy;
  logic [3:0] q_l[$], q_m[$];
  logic [3:0] e_tx_l, e_tx_m;
  logic [1:0] e_oe;
  bit         e_sync, e_done, e_und;

  function automatic bit m_exit();
    return !tx_en || train_req || m_pend;
  endfunction

  function automatic bit m_ready();
    return (m_mode == M_DATA) && (q_l.size() <= 1) && !m_exit();
  endfunction

  task automatic model_reset();
    m_mode = M_HOLD; m_left = HOLD; m_any = 0; m_pend = 0;
    q_l.delete(); q_m.delete();
    e_tx_l = 4'h0; e_tx_m = 4'h0; e_oe = 2'b00; e_sync = 1; e_done = 0; e_und = 0;
  endtask

  task automatic enter_train();
    m_mode = M_TRAIN; m_left = TLEN; e_done = 0;
  endtask

  task automatic model_edge();
    bit acc, leaving;
    acc = valid && m_ready();
    leaving = m_exit() && (q_l.size() <= 1);
    last_acc = acc;
    e_und = 0; e_tx_l = 4'h0; e_tx_m = 4'h0;
    case (m_mode)
      M_HOLD: begin
        e_oe = 2'b00; m_left--;
        if (m_left == 0) begin e_sync = 0; m_mode = M_IDLE; end
      end
      M_IDLE: begin
        e_oe = tx_en ? 2'b11 : 2'b00;
        if (train_req) enter_train();
        else if (tx_en) begin m_mode = M_DATA; m_any = 0; m_pend = 0; end
      end
      M_TRAIN: begin
        e_oe = 2'b11; e_tx_l = 4'b0101; e_tx_m = 4'b0101; m_left--;
        if (m_left == 0) begin e_done = 1; m_mode = M_IDLE; end
      end
      default: begin
        e_oe = 2'b11;
        if (q_l.size() > 0) begin
          e_tx_l = q_l.pop_front(); e_tx_m = q_m.pop_front();
        end else begin
          e_und = m_any;
        end
        if (acc) begin
          q_l.push_back(data[3:0]); q_l.push_back(data[7:4]);
          q_m.push_back(data[7:4]); q_m.push_back(data[3:0]);
          m_any = 1;
        end
        if (train_req) m_pend = 1;
        if (leaving) begin
          if (m_pend) enter_train();
          else m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("tx_lsb", tx_a, e_tx_l);     chk("tx_msb", tx_b, e_tx_m);
    chk("oe_lsb", oe_a, e_oe);       chk("oe_msb", oe_b, e_oe);
    chk("sync_lsb", sync_a, e_sync); chk("sync_msb", sync_b, e_sync);
    chk("done_lsb", done_a, e_done); chk("done_msb", done_b, e_done);
    chk("und_lsb", und_a, e_und);    chk("und_msb", und_b, e_und);
  endtask

  // One FAB_CLK cycle, entered and left at a falling edge.
  task automatic cyc(input bit en, input bit tr, input bit v, input logic [7:0] d);
    tx_en = en; train_req = tr; valid = v; data = d;
    #1;
    last_rdy = rdy_a;
    chk("rdy_lsb", rdy_a, m_ready());
    chk("rdy_msb", rdy_b, m_ready());
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    model_reset();
    chk("rst_tx", tx_a, 8'h0);    chk("rst_oe", oe_a, 8'h0);
    chk("rst_sync", sync_a, 8'h1); chk("rst_rdy", rdy_a, 8'h0);
    chk("rst_done", done_a, 8'h0); chk("rst_und", und_a, 8'h0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic hold_check();
    for (int i = 1; i <= HOLD; i++) begin
      cyc(0, 0, 0, 8'h00);
      chk("hold_sync", sync_a, 8'(i < HOLD));
      chk("hold_oe", oe_a, 8'h0);
    end
  endtask

  typedef struct {
    bit         en;
    bit         v;
    logic [7:0] d;
    logic [3:0] tx;
    bit         und;
    bit         rdy;
  } vec_t;

  vec_t vecs[15];
  bit   rv;
  logic [7:0] rd;

  initial begin
    vecs[0]  = '{1, 0, 8'h00, 4'h0, 0, 0};
    vecs[1]  = '{1, 1, 8'hA5, 4'h0, 0, 1};
    vecs[2]  = '{1, 1, 8'h3C, 4'h5, 0, 0};
    vecs[3]  = '{1, 1, 8'h3C, 4'hA, 0, 1};
    vecs[4]  = '{1, 0, 8'h00, 4'hC, 0, 0};
    vecs[5]  = '{1, 0, 8'h00, 4'h3, 0, 1};
    vecs[6]  = '{1, 0, 8'h00, 4'h0, 1, 1};
    vecs[7]  = '{0, 0, 8'h00, 4'h0, 1, 0};
    vecs[8]  = '{1, 0, 8'h00, 4'h0, 0, 0};
    vecs[9]  = '{1, 1, 8'hA5, 4'h0, 0, 1};
    vecs[10] = '{1, 0, 8'h00, 4'h5, 0, 0};
    vecs[11] = '{1, 0, 8'h00, 4'hA, 0, 1};
    vecs[12] = '{1, 1, 8'h3C, 4'h0, 1, 1};
    vecs[13] = '{1, 0, 8'h00, 4'hC, 0, 0};
    vecs[14] = '{1, 0, 8'h00, 4'h3, 0, 1};

    model_reset();
    @(negedge clk);
    do_reset();
    hold_check();

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].en, 0, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_tx", i), tx_a, vecs[i].tx);
      chk($sformatf("vec%0d_und", i), und_a, vecs[i].und);
      chk($sformatf("vec%0d_rdy", i), last_rdy, vecs[i].rdy);
    end

    // Training request while the first nibble of F0 is on the lane.
    cyc(1, 0, 1, 8'hF0);
    cyc(1, 0, 0, 8'h00);
    chk("t5_first_lsb", tx_a, 8'h0); chk("t5_first_msb", tx_b, 8'hF);
    cyc(1, 1, 0, 8'h00);
    chk("t5_second_lsb", tx_a, 8'hF); chk("t5_second_msb", tx_b, 8'h0);
    chk("t5_rdy", last_rdy, 8'h0);
    for (int i = 1; i <= TLEN; i++) begin
      cyc(1, 0, 0, 8'h00);
      chk("t5_burst", tx_a, 8'h5);
      chk("t5_done", done_a, 8'(i == TLEN));
    end
    cyc(0, 0, 0, 8'h00);
    chk("t5_after", tx_a, 8'h0);

    // Training from IDLE, request held for a few cycles (ignored inside the burst).
    cyc(0, 1, 0, 8'h00);
    chk("t4_entry_done", done_a, 8'h0);
    for (int i = 1; i <= TLEN; i++) begin
      cyc(0, i <= 3, 0, 8'h00);
      chk("t4_burst", tx_a, 8'h5);
      chk("t4_oe", oe_a, 8'h3);
      chk("t4_rdy", last_rdy, 8'h0);
      chk("t4_done", done_a, 8'(i == TLEN));
    end
    cyc(0, 0, 0, 8'h00);
    chk("t4_idle", tx_a, 8'h0);
    chk("t4_sticky", done_a, 8'h1);

    // Reset mid-word, then mid-burst.
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 1, 8'hC3);
    cyc(1, 0, 0, 8'h00);
    chk("t6_first", tx_a, 8'h3);
    do_reset();
    hold_check();
    cyc(0, 1, 0, 8'h00);
    repeat (5) cyc(0, 0, 0, 8'h00);
    do_reset();
    hold_check();

    // Randomized traffic; source holds VALID/DATA until accepted.
    rv = 0; rd = 8'h00; last_acc = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (!(rv && !last_acc)) begin
        rv = ($urandom_range(0, 2) != 0);
        rd = 8'($urandom);
      end
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 39) == 0, rv, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
